// File: rtl/hazard_ctrl.sv
// Issue/stall/flush control for an in-order pipeline. A per-register scoreboard
// covers data hazards, and a two-state FSM covers BEQ/JMP control hazards.
module hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_id,
  input  logic        ir_valid,
  input  logic        reg_update,
  input  logic [4:0]  Ri_in,
  input  logic        br_resolved,
  input  logic        br_taken,
  output logic        issue,
  output logic        stall,
  output logic        flush,
  output logic        br_busy,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] pend [32];

  logic [5:0]  op;
  logic [4:0]  ri, rj, rk;
  logic        is_alu, is_lw, is_sw, is_beq, is_jmp;
  logic        need_ri, need_rj, need_rk, writes;
  logic [31:0] ready_vec, inc_vec, dec_vec;
  logic        srcs_ok, dest_ok, err_set;
  logic        unused_bits;

  assign op = ir_id[31:26];
  assign ri = ir_id[25:21];
  assign rj = ir_id[20:16];
  assign rk = ir_id[15:11];
  assign unused_bits = ^ir_id[10:0];

  assign is_alu = (op[5:4] == 2'b00);
  assign is_lw  = (op == 6'b01_0000);
  assign is_sw  = (op == 6'b01_0001);
  assign is_beq = (op == 6'b10_0000);
  assign is_jmp = (op == 6'b10_0001);

  assign need_rj = is_alu | is_lw | is_sw | is_beq;
  assign need_rk = is_alu;
  assign need_ri = is_sw | is_beq;
  assign writes  = is_alu | is_lw;

  // A count of one retiring this cycle is readable thanks to the negedge regfile write.
  always_comb begin
    ready_vec = '0;
    for (int r = 0; r < 32; r++) begin
      ready_vec[r] = (pend[r] == '0) ||
                     ((pend[r] == CNT_W'(1)) && reg_update && (Ri_in == 5'(r)));
    end
  end

  assign srcs_ok = (~need_ri | ready_vec[ri]) &
                   (~need_rj | ready_vec[rj]) &
                   (~need_rk | ready_vec[rk]);
  assign dest_ok = ~writes | (pend[ri] != MAX_CNT);

  assign inc_vec = (issue & writes) ? (32'd1 << ri) : 32'd0;
  assign dec_vec = reg_update ? (32'd1 << Ri_in) : 32'd0;
  assign err_set = reg_update & (pend[Ri_in] == '0) & ~inc_vec[Ri_in];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          pend[r] <= pend[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0)) begin
          pend[r] <= pend[r] - CNT_W'(1);
        end
      end
      if (err_set) sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      flush <= 1'b0;
    end else begin
      state <= state_nx;
      flush <= (state == BR_WAIT) & br_resolved & br_taken;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue && (is_beq || is_jmp)) state_nx = BR_WAIT;
      BR_WAIT: if (br_resolved) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue   = rst_n & ir_valid & srcs_ok & dest_ok & (state == IDLE) & ~flush;
    stall   = rst_n & ir_valid & ~issue;
    br_busy = rst_n & (state == BR_WAIT);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl with a behavioural scoreboard
// model built from counts per register and a "branch outstanding" flag.
module tb_hazard_ctrl;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam logic [5:0] OP_ALU = 6'h05, OP_LW = 6'h10, OP_SW = 6'h11;
  localparam logic [5:0] OP_BEQ = 6'h20, OP_JMP = 6'h21, OP_NOP = 6'h3F;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] ir_id = '0;
  logic        ir_valid = 1'b0, reg_update = 1'b0, br_resolved = 1'b0, br_taken = 1'b0;
  logic [4:0]  Ri_in = '0;
  logic        issue, stall, flush, br_busy, sb_err;
  wire  [4:0]  obs = {issue, stall, flush, br_busy, sb_err};

  int checks = 0, errors = 0;
  int m_pend [32];
  bit m_br, m_flush, m_err;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ir_id(ir_id), .ir_valid(ir_valid),
    .reg_update(reg_update), .Ri_in(Ri_in), .br_resolved(br_resolved), .br_taken(br_taken),
    .issue(issue), .stall(stall), .flush(flush), .br_busy(br_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_issue();
    logic [5:0] op;
    int src[$];
    int dst, ri, rj, rk;
    op = ir_id[31:26];
    ri = int'(ir_id[25:21]);
    rj = int'(ir_id[20:16]);
    rk = int'(ir_id[15:11]);
    dst = -1;
    if (rst_n !== 1'b1 || ir_valid !== 1'b1 || m_br || m_flush) return 1'b0;
    if (op[5:4] == 2'b00) begin src.push_back(rj); src.push_back(rk); dst = ri; end
    else if (op == OP_LW) begin src.push_back(rj); dst = ri; end
    else if (op == OP_SW || op == OP_BEQ) begin src.push_back(ri); src.push_back(rj); end
    foreach (src[i]) begin
      int s;
      s = src[i];
      if (!(m_pend[s] == 0 || (m_pend[s] == 1 && reg_update && int'(Ri_in) == s))) return 1'b0;
    end
    if (dst >= 0 && m_pend[dst] >= MAXC) return 1'b0;
    return 1'b1;
  endfunction

  // Expected {issue, stall, flush, br_busy, sb_err} for the current inputs.
  function automatic logic [4:0] exp_vec();
    bit ei;
    ei = exp_issue();
    return {ei, rst_n & ir_valid & ~ei, m_flush, rst_n & m_br, m_err};
  endfunction

  task automatic model_edge();
    bit iss;
    int dst;
    logic [5:0] op;
    iss = exp_issue();
    op  = ir_id[31:26];
    if (!rst_n) begin
      foreach (m_pend[r]) m_pend[r] = 0;
      m_br = 0; m_flush = 0; m_err = 0;
      return;
    end
    dst = (op[5:4] == 2'b00 || op == OP_LW) ? int'(ir_id[25:21]) : -1;
    m_flush = m_br && br_resolved && br_taken;
    if (m_br) m_br = !br_resolved;
    else      m_br = iss && (op == OP_BEQ || op == OP_JMP);
    if (iss && dst >= 0) m_pend[dst]++;
    if (reg_update) begin
      if (m_pend[Ri_in] == 0) m_err = 1;
      else                    m_pend[Ri_in]--;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic v, input logic [5:0] op, input int ri, input int rj, input int rk);
    ir_valid = v;
    ir_id    = {op, 5'(ri), 5'(rj), 5'(rk), 11'($urandom)};
  endtask

  task automatic idle_inputs();
    set_ir(1'b0, OP_NOP, 0, 0, 0);
    reg_update = 0; Ri_in = '0; br_resolved = 0; br_taken = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_ir(1'b1, OP_ALU, 1, 2, 3);
    reg_update = 1; Ri_in = 5'd4; br_resolved = 1; br_taken = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({issue, stall, br_busy, flush, sb_err} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: observed %b required 00000", i, {issue, stall, br_busy, flush, sb_err});
      end
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    set_ir(1'b1, OP_ALU, 1, 2, 3);
    #2;
    checks++;
    if (obs !== exp_vec() || issue !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: observed %b expected %b", obs, exp_vec());
    end
    cycle();
  endtask

  task automatic test_raw();
    do_reset();
    set_ir(1'b1, OP_ALU, 3, 1, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_ir(1'b1, OP_ALU, 4, 3, 1);
      if (i == 4) begin reg_update = 1; Ri_in = 5'd3; end
      #2;
      checks++;
      if (obs !== exp_vec() || issue !== (i == 0 || i == 4) || stall !== (i > 0 && i < 4)) begin
        errors++;
        $display("[TB] FAIL raw_stall step %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
    reg_update = 0;
    set_ir(1'b1, OP_SW, 3, 3, 0);
    #2;
    checks++;
    if (obs !== exp_vec() || issue !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_cleared: observed %b expected %b", obs, exp_vec());
    end
    cycle();
  endtask

  task automatic test_dest_saturate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) set_ir(1'b1, OP_LW, 5, 0, 0);
      else       set_ir(1'b1, OP_ALU, 5, 0, 0);
      reg_update = (i == 5);
      Ri_in      = 5'd5;
      #2;
      checks++;
      if (obs !== exp_vec() || (i < 3 && issue !== 1'b1) || (i == 3 && stall !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL dest_saturate step %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
    reg_update = 0;
  endtask

  task automatic test_branch_taken();
    do_reset();
    set_ir(1'b1, OP_BEQ, 1, 2, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) set_ir(1'b1, OP_NOP, 0, 0, 0);
      br_resolved = (i == 3);
      br_taken    = (i == 3);
      #2;
      checks++;
      if (obs !== exp_vec() || issue !== (i == 0 || i == 5) || flush !== (i == 4) ||
          br_busy !== (i >= 1 && i <= 3)) begin
        errors++;
        $display("[TB] FAIL branch_taken step %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
  endtask

  task automatic test_branch_not_taken();
    do_reset();
    set_ir(1'b1, OP_JMP, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_ir(1'b1, OP_ALU, 9, 1, 2);
      br_resolved = (i == 1 || i == 3);
      br_taken    = (i == 3);
      #2;
      checks++;
      if (obs !== exp_vec() || issue !== (i != 1) || flush !== 1'b0 || br_busy !== (i == 1)) begin
        errors++;
        $display("[TB] FAIL branch_not_taken step %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
    br_resolved = 0; br_taken = 0;
  endtask

  task automatic test_sb_err();
    do_reset();
    reg_update = 1; Ri_in = 5'd7;
    cycle();
    reg_update = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_ir(1'b1, OP_ALU, 7, 1, 1);
      else        set_ir(1'b0, OP_NOP, 0, 0, 0);
      reg_update = (i == 1);
      #2;
      checks++;
      if (obs !== exp_vec() || sb_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sb_err_sticky step %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
    do_reset();
    #2;
    checks++;
    if (obs !== exp_vec() || sb_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_err_clear: observed %b expected %b", obs, exp_vec());
    end
    cycle();
  endtask

  task automatic test_reset_in_branch();
    do_reset();
    set_ir(1'b1, OP_ALU, 2, 0, 0); cycle();
    set_ir(1'b1, OP_ALU, 2, 0, 0); cycle();
    set_ir(1'b1, OP_BEQ, 8, 9, 0); cycle();
    set_ir(1'b1, OP_NOP, 0, 0, 0);
    #2;
    checks++;
    if (obs !== exp_vec() || br_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_branch_pre: observed %b expected %b", obs, exp_vec());
    end
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    set_ir(1'b1, OP_ALU, 10, 2, 2);
    #2;
    checks++;
    if (obs !== exp_vec() || issue !== 1'b1 || br_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_branch_post: observed %b expected %b", obs, exp_vec());
    end
    cycle();
  endtask

  task automatic test_random();
    logic [5:0] nops [5] = '{6'h12, 6'h1F, 6'h22, 6'h30, 6'h3F};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int kind, r;
      logic [5:0] op;
      kind = $urandom_range(0, 5);
      case (kind)
        0: op = {2'b00, 4'($urandom)};
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_JMP;
        default: op = nops[$urandom_range(0, 4)];
      endcase
      set_ir($urandom_range(0, 7) != 0, op, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      r = $urandom_range(0, 5);
      reg_update  = $urandom_range(0, 1) && (m_pend[r] > 0 || $urandom_range(0, 19) == 0);
      Ri_in       = 5'(r);
      br_resolved = m_br ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      br_taken    = $urandom_range(0, 1);
      rst_n       = ($urandom_range(0, 99) != 0);
      #2;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: observed %b expected %b", i, obs, exp_vec());
      end
      cycle();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    foreach (m_pend[r]) m_pend[r] = 0;
    m_br = 0; m_flush = 0; m_err = 0;
    test_reset();
    test_raw();
    test_dest_saturate();
    test_branch_taken();
    test_branch_not_taken();
    test_sb_err();
    test_reset_in_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; max count is 2^CNT_W-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ir_id  input  32  instruction held in IF/ID, fields op[31:26], Ri[25:21], Rj[20:16], Rk[15:11].
REQ-005 ir_valid  input  1  ir_id holds a real instruction.
REQ-006 reg_update  input  1  writeback strobe to register file this cycle.
REQ-007 Ri_in  input  5  writeback destination register.
REQ-008 br_resolved  input  1  pending BEQ/JMP resolved in EX this cycle.
REQ-009 br_taken  input  1  resolution outcome; valid only with br_resolved.
REQ-010 issue  output  1  instruction in ir_id advances into decode this cycle.
REQ-011 stall  output  1  hold PC and IF/ID; equals ir_valid & ~issue.
REQ-012 flush  output  1  squash IF/ID contents; one-cycle pulse.
REQ-013 br_busy  output  1  control hazard FSM in BR_WAIT.
REQ-014 sb_err  output  1  sticky scoreboard error flag.

Function
REQ-015 Opcode classes: op[5:4]=00 ALU reads Rj,Rk writes Ri; 6'b01_0000 LW reads Rj writes Ri; 6'b01_0001 SW reads Ri,Rj no write; 6'b10_0000 BEQ reads Ri,Rj; 6'b10_0001 JMP reads none; all other opcodes NOP (no reads, no writes, always issuable).
REQ-016 Scoreboard: 32 counters pend[r] of CNT_W bits, one per register, R0 tracked like any other.
REQ-017 A source register s is ready when pend[s]==0, or pend[s]==1 and reg_update & Ri_in==s in the same cycle (negedge register-file write makes the value readable).
REQ-018 issue = ir_valid & all sources ready & pend[dest] != max count (writers only) & FSM in IDLE & ~flush; combinational.
REQ-019 On issue of a writer: pend[Ri] increments at the clock edge.
REQ-020 On reg_update: pend[Ri_in] decrements at the clock edge.
REQ-021 Issue of writer to r and reg_update to r in the same cycle: pend[r] unchanged.
REQ-022 reg_update to r with pend[r]==0 and no same-cycle issue to r: pend[r] stays 0, sb_err set to 1 and held until reset.
REQ-023 Counters never wrap; the REQ-018 dest check guarantees no increment past max.
REQ-024 FSM states IDLE, BR_WAIT; IDLE -> BR_WAIT on issue of BEQ or JMP; otherwise holds.
REQ-025 BR_WAIT -> IDLE on br_resolved; br_busy=1 exactly while in BR_WAIT; br_resolved in IDLE is ignored.
REQ-026 flush registered: asserted for exactly the one cycle following a cycle with br_resolved & br_taken in BR_WAIT; no issue during that cycle.
REQ-027 br_resolved with br_taken=0: return to IDLE, no flush; issue may occur the following cycle.
REQ-028 Scoreboard updates from reg_update continue in BR_WAIT and during flush.

Reset
REQ-029 rst_n=0 at a rising edge: all pend[] = 0, FSM = IDLE, flush = 0, sb_err = 0, regardless of operation in progress.
REQ-030 While rst_n=0: issue = 0, stall = 0, br_busy = 0; first issue possible in the cycle after rst_n returns to 1.

Verification
REQ-031 ALU R3<-R1,R2 issued, next ALU R4<-R3,R1 valid -> stall=1, issue=0 until cycle with reg_update, Ri_in=3; issue=1 in that same cycle, pend[3]=0 after.
REQ-032 Three writers to R5 issued, fourth writer to R5 valid, no writebacks -> stall=1, pend[5]=3; one reg_update Ri_in=5 -> fourth issues, pend[5] remains 3.
REQ-033 BEQ issued -> br_busy=1 next cycle, NOP valid stalls; br_resolved=1, br_taken=1 -> flush=1 for one cycle, br_busy=0, issue resumes cycle after flush.
REQ-034 BEQ issued, br_resolved=1, br_taken=0 -> no flush, br_busy=0 next cycle, following instruction issues immediately.
REQ-035 reg_update Ri_in=7 with pend[7]=0 -> sb_err=1, held across later traffic, cleared only by rst_n=0.
REQ-036 rst_n=0 in BR_WAIT with pend[2]=2 -> next cycle br_busy=0, pend[2]=0, instruction reading R2 issues immediately after release.
